esm_dwell_reporter: RTL

Downstream consumer of the dwell controller's `Dwell_active` / `Dwell_data` / `Dwell_sequence_num` outputs. For each completed dwell it:
- captures the dwell metadata and a start timestamp;
- measures the actual active duration in clock cycles;
- emits one fixed-length summary message on a 32-bit AXI-Stream toward the host report path.

A single report buffer decouples dwell timing from stream backpressure. Reports that cannot be buffered are dropped and counted.

---
 rtl/esm_pkg.sv | 60 ++++++
 rtl/esm_dwell_reporter_if.sv | 10 +
 rtl/esm_dwell_report_serializer.sv | 74 +++++++
 rtl/esm_dwell_reporter.sv | 106 ++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared ESM types and constants for the dwell summary report path.
// ESM_DWELL_REPORTER_TIMESTAMP_EN adds the 64-bit start timestamp (words 7-8) to each report.
package esm_pkg;

    localparam int unsigned esm_axis_width = 32;

    localparam logic [31:0] esm_report_magic_num                  = 32'hE5D3_A11C;
    localparam logic [7:0]  esm_module_id_dwell_controller        = 8'h03;
    localparam logic [7:0]  esm_report_message_type_dwell_summary = 8'h21;

`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
    localparam int unsigned esm_dwell_report_num_words = 10;
`else
    localparam int unsigned esm_dwell_report_num_words = 8;
`endif

    typedef struct packed {
        logic [15:0] frequency;
        logic [15:0] tag;
        logic [31:0] duration;
        logic [7:0]  fast_lock_profile;
        logic [7:0]  gain;
    } esm_dwell_metadata_t;

    typedef struct packed {
        esm_dwell_metadata_t meta;
        logic [31:0]         sequence_num;
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
        logic [63:0]         timestamp;
`endif
        logic [31:0]         active_cycles;
        logic [15:0]         drop_count;
    } esm_dwell_report_t;

    function automatic logic [31:0] esm_dwell_report_word(esm_dwell_report_t rpt,
                                                          logic [31:0]       rpt_seq,
                                                          logic [3:0]        idx);
        logic [31:0] word;
        case (idx)
            4'd0:    word = esm_report_magic_num;
            4'd1:    word = rpt_seq;
            4'd2:    word = {esm_module_id_dwell_controller, esm_report_message_type_dwell_summary,
                             rpt.drop_count};
            4'd3:    word = rpt.sequence_num;
            4'd4:    word = {rpt.meta.frequency, rpt.meta.tag};
            4'd5:    word = rpt.meta.duration;
            4'd6:    word = {16'h0, rpt.meta.fast_lock_profile, rpt.meta.gain};
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
            4'd7:    word = rpt.timestamp[31:0];
            4'd8:    word = rpt.timestamp[63:32];
            4'd9:    word = rpt.active_cycles;
`else
            4'd7:    word = rpt.active_cycles;
`endif
            default: word = 32'h0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/esm_dwell_reporter_if.sv
// 32-bit AXI-Stream carrying dwell summary messages toward the host report path.
interface esm_dwell_reporter_if;
    logic        Axis_valid;
    logic        Axis_ready;
    logic        Axis_last;
    logic [31:0] Axis_data;

    modport master (output Axis_valid, output Axis_last, output Axis_data, input Axis_ready);
    modport slave  (input Axis_valid, input Axis_last, input Axis_data, output Axis_ready);
endinterface

// File: rtl/esm_dwell_report_serializer.sv
// Holds one buffered dwell report and streams it out word by word on AXI-Stream.
module esm_dwell_report_serializer
    import esm_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  esm_dwell_report_t           report_i,
    output logic                        busy_o,
    esm_dwell_reporter_if.master        axis
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    esm_dwell_report_t buf_q, buf_d;
    logic [3:0]        idx_q, idx_d;
    logic [31:0]       rpt_seq_q, rpt_seq_d;
    logic              sending;
    logic              last_word;

    assign sending   = (state_q == StSend);
    assign last_word = (idx_q == 4'(esm_dwell_report_num_words - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            buf_q     <= '0;
            idx_q     <= '0;
            rpt_seq_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            rpt_seq_q <= rpt_seq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        rpt_seq_d = rpt_seq_q;
        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    state_d = StSend;
                    buf_d   = report_i;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (axis.Axis_ready) begin
                    if (last_word) begin
                        state_d   = StIdle;
                        rpt_seq_d = rpt_seq_q + 32'd1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Buffer occupancy is the SEND state itself, so it only frees after the last beat.
    always_comb begin
        busy_o          = sending;
        axis.Axis_valid = sending;
        axis.Axis_last  = sending && last_word;
        axis.Axis_data  = sending ? esm_dwell_report_word(buf_q, rpt_seq_q, idx_q) : 32'h0;
    end

endmodule

// File: rtl/esm_dwell_reporter.sv
// Captures each dwell, measures its active length and queues one summary report for streaming.
// ESM_DWELL_REPORTER_TIMESTAMP_EN enables the free-running timestamp and its two report words.
module esm_dwell_reporter
    import esm_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Enable,
    input  logic                 Dwell_active,
    input  esm_dwell_metadata_t  Dwell_data,
    input  logic [31:0]          Dwell_sequence_num,
    esm_dwell_reporter_if.master axis
);

    if (AXI_DATA_WIDTH != esm_axis_width) begin : g_width_check
        $error("esm_dwell_reporter supports AXI_DATA_WIDTH == 32 only");
    end

    logic                dwell_active_q;
    logic                report_en_q;
    esm_dwell_metadata_t meta_q;
    logic [31:0]         dseq_q;
    logic [31:0]         count_q, count_d;
    logic [15:0]         drop_q, drop_d;
    logic                dwell_start, dwell_end;
    logic                busy, load, drop_evt;
    esm_dwell_report_t   report;

    assign dwell_start = Dwell_active && !dwell_active_q;
    assign dwell_end   = !Dwell_active && dwell_active_q;
    assign load        = dwell_end && report_en_q && !busy;
    assign drop_evt    = dwell_end && report_en_q && busy;

    always_comb begin
        count_d = count_q;
        if (dwell_start) begin
            count_d = 32'd1;
        end else if (Dwell_active && (count_q != '1)) begin
            count_d = count_q + 32'd1;
        end
        drop_d = drop_q;
        if (drop_evt && (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            dwell_active_q <= 1'b0;
            report_en_q    <= 1'b0;
            meta_q         <= '0;
            dseq_q         <= '0;
            count_q        <= '0;
            drop_q         <= '0;
        end else begin
            dwell_active_q <= Dwell_active;
            count_q        <= count_d;
            drop_q         <= drop_d;
            if (dwell_start) begin
                meta_q      <= Dwell_data;
                dseq_q      <= Dwell_sequence_num;
                report_en_q <= Enable;
            end
        end
    end

`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
    logic [63:0] ts_q, ts_cap_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ts_q     <= '0;
            ts_cap_q <= '0;
        end else begin
            ts_q <= ts_q + 64'd1;
            if (dwell_start) begin
                ts_cap_q <= ts_q;
            end
        end
    end
`endif

    // The drop count is taken as it stands at load time.
    always_comb begin
        report               = '0;
        report.meta          = meta_q;
        report.sequence_num  = dseq_q;
`ifdef ESM_DWELL_REPORTER_TIMESTAMP_EN
        report.timestamp     = ts_cap_q;
`endif
        report.active_cycles = count_q;
        report.drop_count    = drop_q;
    end

    esm_dwell_report_serializer u_serializer (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .load_i   (load),
        .report_i (report),
        .busy_o   (busy),
        .axis     (axis)
    );

endmodule
